switch_lookup: RTL and testbench

Per-port forwarding-decision stage for the three-port switch datapath. It accepts byte-wide frame streams from ports 0–2, learns source addresses into a shared associative table, and looks up each frame's destination. It emits one result byte plus a one-cycle `ramen_n` strobe per completed frame, feeding the `result_n`/`ramen_n` inputs of the downstream result buffer.

---
 rtl/switch_pkg.sv | 26 ++
 rtl/lookup_port_fsm.sv | 81 ++++++++
 rtl/switch_lookup.sv | 143 ++++++++++++++
 tb/tb_switch_lookup.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types and constants for the switch lookup stage
package switch_pkg;

  typedef enum logic [1:0] {
    UNICAST = 2'b00,
    FLOOD   = 2'b01,
    RUNT    = 2'b10,
    DROP    = 2'b11
  } status_e;

  typedef logic [1:0] port_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] addr;
    port_t      port;
  } entry_t;

  localparam port_t      FLOOD_PORT = 2'b11;
  localparam logic [7:0] BCAST_ADDR = 8'hFF;

  function automatic logic [7:0] fmt_result(status_e s, port_t p);
    return {s, 4'b0000, p};
  endfunction

endpackage

// File: rtl/lookup_port_fsm.sv
// rtl/lookup_port_fsm.sv - per-port frame parser, learn request and result formatting
module lookup_port_fsm
  import switch_pkg::*;
#(
  parameter port_t PORT_ID = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       sop,
  input  logic       eop,
  input  logic       hit,
  input  port_t      hit_port,
  output logic [7:0] dest,
  output logic       learn_req,
  output logic [7:0] learn_addr,
  output logic [7:0] result,
  output logic       ramen
);

  typedef enum logic [1:0] {IDLE, DST, BODY} state_e;

  state_e     state, state_nxt;
  logic [7:0] dest_nxt;
  logic [7:0] result_nxt;
  logic       done, runt;

  always_comb begin
    state_nxt  = state;
    dest_nxt   = dest;
    learn_req  = 1'b0;
    learn_addr = data;
    done       = 1'b0;
    runt       = 1'b0;
    if (valid) begin
      // sop always restarts parsing, even mid-frame; the old frame is dropped silently
      if (sop && eop) begin
        runt      = 1'b1;
        state_nxt = IDLE;
      end else if (sop) begin
        dest_nxt  = data;
        state_nxt = DST;
      end else if (state == DST) begin
        learn_req = (data != BCAST_ADDR);
        done      = eop;
        state_nxt = eop ? IDLE : BODY;
      end else if (state == BODY && eop) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    if (runt)
      result_nxt = fmt_result(RUNT, FLOOD_PORT);
    else if (dest == BCAST_ADDR || !hit)
      result_nxt = fmt_result(FLOOD, FLOOD_PORT);
    else if (hit_port == PORT_ID)
      result_nxt = fmt_result(DROP, hit_port);
    else
      result_nxt = fmt_result(UNICAST, hit_port);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      dest   <= 8'h00;
      result <= 8'h00;
      ramen  <= 1'b0;
    end else begin
      state <= state_nxt;
      dest  <= dest_nxt;
      ramen <= done | runt;
      if (done | runt)
        result <= result_nxt;
    end
  end

endmodule

// File: rtl/switch_lookup.sv
// rtl/switch_lookup.sv - shared learned-address table, learn arbiter and three lookup ports
module switch_lookup
  import switch_pkg::*;
#(
  parameter int TABLE_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [7:0] data3,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  input  logic       sop1,
  input  logic       sop2,
  input  logic       sop3,
  input  logic       eop1,
  input  logic       eop2,
  input  logic       eop3,
  output logic [7:0] result1,
  output logic [7:0] result2,
  output logic [7:0] result3,
  output logic       ramen1,
  output logic       ramen2,
  output logic       ramen3
);

  localparam int IW = $clog2(TABLE_DEPTH);

  logic [2:0][7:0] data_a, dest_a, laddr_a, result_a, eff_addr, pend_addr;
  logic [2:0]      valid_a, sop_a, eop_a, lreq_a, hit_a, ramen_a, pend_v, eff_v;
  port_t [2:0]     hit_port_a;
  entry_t          tbl [TABLE_DEPTH];
  port_t           rr_ptr, gnt, cand;
  logic            gnt_v, wr_hit, wr_inv;
  logic [7:0]      wr_addr;
  logic [IW-1:0]   hit_idx, inv_idx, wr_idx, repl_ptr;

  assign data_a  = {data3, data2, data1};
  assign valid_a = {valid3, valid2, valid1};
  assign sop_a   = {sop3, sop2, sop1};
  assign eop_a   = {eop3, eop2, eop1};
  assign {result3, result2, result1} = result_a;
  assign {ramen3, ramen2, ramen1}    = ramen_a;

  function automatic port_t next_port(port_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_port
    lookup_port_fsm #(.PORT_ID(port_t'(g))) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .data       (data_a[g]),
      .valid      (valid_a[g]),
      .sop        (sop_a[g]),
      .eop        (eop_a[g]),
      .hit        (hit_a[g]),
      .hit_port   (hit_port_a[g]),
      .dest       (dest_a[g]),
      .learn_req  (lreq_a[g]),
      .learn_addr (laddr_a[g]),
      .result     (result_a[g]),
      .ramen      (ramen_a[g])
    );
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      hit_a[p]      = 1'b0;
      hit_port_a[p] = 2'd0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        if (tbl[i].valid && tbl[i].addr == dest_a[p]) begin
          hit_a[p]      = 1'b1;
          hit_port_a[p] = tbl[i].port;
        end
      end
    end
  end

  // A request arriving this cycle competes immediately so uncontended learns land a cycle early
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      eff_v[p]    = pend_v[p] | lreq_a[p];
      eff_addr[p] = lreq_a[p] ? laddr_a[p] : pend_addr[p];
    end
  end

  always_comb begin
    gnt_v = 1'b0;
    gnt   = rr_ptr;
    cand  = rr_ptr;
    for (int i = 0; i < 3; i++) begin
      if (!gnt_v && eff_v[cand]) begin
        gnt_v = 1'b1;
        gnt   = cand;
      end
      cand = next_port(cand);
    end
  end

  always_comb begin
    wr_addr = eff_addr[gnt];
    wr_hit  = 1'b0;
    wr_inv  = 1'b0;
    hit_idx = '0;
    inv_idx = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (tbl[i].valid && tbl[i].addr == wr_addr) begin
        wr_hit  = 1'b1;
        hit_idx = IW'(i);
      end
      if (!tbl[i].valid) begin
        wr_inv  = 1'b1;
        inv_idx = IW'(i);
      end
    end
    wr_idx = wr_hit ? hit_idx : (wr_inv ? inv_idx : repl_ptr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TABLE_DEPTH; i++)
        tbl[i] <= '0;
      pend_v    <= '0;
      pend_addr <= '0;
      rr_ptr    <= 2'd0;
      repl_ptr  <= '0;
    end else begin
      pend_v    <= eff_v;
      pend_addr <= eff_addr;
      if (gnt_v) begin
        pend_v[gnt] <= 1'b0;
        tbl[wr_idx] <= '{valid: 1'b1, addr: wr_addr, port: gnt};
        rr_ptr      <= next_port(gnt);
        if (!wr_hit && !wr_inv)
          repl_ptr <= repl_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_lookup.sv
// tb/tb_switch_lookup.sv - scoreboard bench for switch_lookup with a frame-level reference model
module tb_switch_lookup;

  localparam int D = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2:0][7:0] din = '0;
  logic [2:0]      vin = '0, sin = '0, ein = '0;
  logic [2:0][7:0] res;
  logic [2:0]      ram;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  int nstrobe = 0;
  logic [7:0] last_res [3];

  // reference model state
  int         m_st [3];
  logic [7:0] m_dest [3];
  bit         t_v [D];
  logic [7:0] t_a [D];
  int         t_p [D];
  int         repl, rr;
  bit         p_v [3];
  logic [7:0] p_a [3];

  longint unsigned q0[$], q1[$], q2[$];

  switch_lookup #(.TABLE_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .data1(din[0]), .data2(din[1]), .data3(din[2]),
    .valid1(vin[0]), .valid2(vin[1]), .valid3(vin[2]),
    .sop1(sin[0]), .sop2(sin[1]), .sop3(sin[2]),
    .eop1(ein[0]), .eop2(ein[1]), .eop3(ein[2]),
    .result1(res[0]), .result2(res[1]), .result3(res[2]),
    .ramen1(ram[0]), .ramen2(ram[1]), .ramen3(ram[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int p, input logic [7:0] r);
    longint unsigned x;
    x = (longint'(cyc + 1) << 8) | longint'(r);
    case (p)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  function automatic int qsize(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic longint unsigned qfront(input int p);
    case (p)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int p);
    case (p)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic m_reset();
    for (int i = 0; i < D; i++) begin t_v[i] = 0; t_a[i] = 0; t_p[i] = 0; end
    for (int p = 0; p < 3; p++) begin m_st[p] = 0; m_dest[p] = 0; p_v[p] = 0; p_a[p] = 0; end
    repl = 0;
    rr = 0;
  endtask

  // status in bits 7:6 as plain arithmetic: unicast 0, flood 64, runt 128, drop 192
  function automatic logic [7:0] m_lookup(input int p);
    if (m_dest[p] == 8'hFF) return 8'd64 + 8'd3;
    for (int i = 0; i < D; i++)
      if (t_v[i] && t_a[i] == m_dest[p])
        return (t_p[i] == p) ? 8'(192 + t_p[i]) : 8'(t_p[i]);
    return 8'd64 + 8'd3;
  endfunction

  task automatic m_learn(input logic [7:0] a, input int port);
    for (int i = 0; i < D; i++)
      if (t_v[i] && t_a[i] == a) begin t_p[i] = port; return; end
    for (int i = 0; i < D; i++)
      if (!t_v[i]) begin t_v[i] = 1; t_a[i] = a; t_p[i] = port; return; end
    t_a[repl] = a;
    t_p[repl] = port;
    repl = (repl + 1) % D;
  endtask

  task automatic model_cycle();
    bit nreq [3];
    logic [7:0] naddr [3];
    int gp, q;
    if (reset) begin m_reset(); return; end
    for (int p = 0; p < 3; p++) begin
      nreq[p] = 0;
      naddr[p] = 0;
      if (vin[p]) begin
        if (sin[p] && ein[p]) begin
          push_exp(p, 8'd128 + 8'd3);
          m_st[p] = 0;
        end else if (sin[p]) begin
          m_dest[p] = din[p];
          m_st[p] = 1;
        end else if (m_st[p] == 1) begin
          if (din[p] != 8'hFF) begin nreq[p] = 1; naddr[p] = din[p]; end
          if (ein[p]) begin push_exp(p, m_lookup(p)); m_st[p] = 0; end
          else m_st[p] = 2;
        end else if (m_st[p] == 2 && ein[p]) begin
          push_exp(p, m_lookup(p));
          m_st[p] = 0;
        end
      end
    end
    for (int p = 0; p < 3; p++)
      if (nreq[p]) begin p_v[p] = 1; p_a[p] = naddr[p]; end
    gp = -1;
    for (int i = 0; i < 3; i++) begin
      q = (rr + i) % 3;
      if (gp < 0 && p_v[q]) gp = q;
    end
    if (gp >= 0) begin
      p_v[gp] = 0;
      rr = (gp + 1) % 3;
      m_learn(p_a[gp], gp);
    end
  endtask

  task automatic drive(input bit rst, input logic [2:0] v, input logic [2:0] s, input logic [2:0] e,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    @(posedge clk);
    #1;
    reset = rst;
    vin = v;
    sin = s;
    ein = e;
    din = {d2, d1, d0};
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic send(input int p, input bit s, input bit e, input logic [7:0] d);
    logic [2:0] m;
    m = 3'(1 << p);
    drive(0, m, s ? m : 3'b000, e ? m : 3'b000, d, d, d);
  endtask

  task automatic frame3(input int p, input logic [7:0] dst, input logic [7:0] src, input logic [7:0] pl);
    send(p, 1, 0, dst);
    send(p, 0, 0, src);
    send(p, 0, 1, pl);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (qsize(p) > 0 && int'(qfront(p) >> 8) < cyc) begin
        tests++;
        errors++;
        $display("FAIL missing_strobe_port%0d: no strobe at cycle %0d, expected result %02h",
                 p + 1, int'(qfront(p) >> 8), qfront(p) & 64'hFF);
        qpop(p);
      end
      if (ram[p] === 1'b1) begin
        nstrobe++;
        last_res[p] = res[p];
        tests++;
        if (qsize(p) == 0) begin
          errors++;
          $display("FAIL extra_strobe_port%0d: strobe with result %02h at cycle %0d, expected none",
                   p + 1, res[p], cyc);
        end else begin
          if (res[p] !== 8'(qfront(p)) || int'(qfront(p) >> 8) != cyc) begin
            errors++;
            $display("FAIL result_port%0d: got %02h at cycle %0d, expected %02h at cycle %0d",
                     p + 1, res[p], cyc, 8'(qfront(p)), int'(qfront(p) >> 8));
          end
          qpop(p);
        end
      end
    end
  end

  function automatic logic [7:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return 8'hFF;
    return 8'($urandom_range(0, 23));
  endfunction

  initial begin
    int rem [3];
    int pos [3];
    int base;
    logic [2:0] v, s, e;
    logic [7:0] d [3];

    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("reset_result%0d", p + 1), 32'(res[p]), 32'h0);
      chk($sformatf("reset_ramen%0d", p + 1), 32'(ram[p]), 32'h0);
    end

    frame3(0, 8'h22, 8'h11, 8'hAA); idle(2);
    chk("flood_first", 32'(last_res[0]), 32'h43);
    send(1, 1, 0, 8'h11); send(1, 0, 1, 8'h33); idle(2);
    chk("unicast_learned", 32'(last_res[1]), 32'h00);
    send(0, 1, 0, 8'h11); send(0, 0, 1, 8'h44); idle(2);
    chk("drop_same_port", 32'(last_res[0]), 32'hC0);
    send(2, 1, 1, 8'h5A); idle(2);
    chk("runt", 32'(last_res[2]), 32'h83);

    base = nstrobe;
    send(1, 1, 0, 8'h11); send(1, 0, 0, 8'h55); send(1, 0, 0, 8'h01);
    send(1, 1, 0, 8'h33); send(1, 0, 1, 8'h66); idle(2);
    chk("abort_strobes", 32'(nstrobe - base), 32'd1);
    chk("abort_result", 32'(last_res[1]), 32'hC1);

    drive(0, 3'b111, 3'b111, 3'b000, 8'h70, 8'h70, 8'h70);
    drive(0, 3'b111, 3'b000, 3'b000, 8'h81, 8'h82, 8'h83);
    drive(0, 3'b111, 3'b000, 3'b111, 8'h00, 8'h00, 8'h00);
    idle(3);
    send(2, 1, 0, 8'h81); send(2, 0, 1, 8'hFF); idle(2);
    chk("contend_learn_p1", 32'(last_res[2]), 32'h00);
    send(0, 1, 0, 8'h83); send(0, 0, 1, 8'hFF); idle(2);
    chk("contend_learn_p3", 32'(last_res[0]), 32'h02);

    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) frame3(0, 8'hFF, 8'(8'h20 + i), 8'h00);
    idle(2);
    send(1, 1, 0, 8'h20); send(1, 0, 1, 8'hFF); idle(2);
    chk("replaced_entry_floods", 32'(last_res[1]), 32'h43);
    send(1, 1, 0, 8'h21); send(1, 0, 1, 8'hFF); idle(2);
    chk("kept_entry_hits", 32'(last_res[1]), 32'h00);

    drive(0, 3'b111, 3'b111, 3'b000, 8'h90, 8'h90, 8'h90);
    drive(0, 3'b111, 3'b000, 3'b000, 8'hA1, 8'hA2, 8'hA3);
    idle(1);
    base = nstrobe;
    drive(1, 3'b111, 3'b000, 3'b111, 8'h00, 8'h00, 8'h00);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("reset_midframe_strobes", 32'(nstrobe - base), 32'd0);
    send(0, 1, 0, 8'hA2); send(0, 0, 1, 8'hFF); idle(2);
    chk("post_reset_flood", 32'(last_res[0]), 32'h43);

    for (int p = 0; p < 3; p++) begin rem[p] = 0; pos[p] = 0; end
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) < 3) begin
        for (int p = 0; p < 3; p++) rem[p] = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        continue;
      end
      for (int p = 0; p < 3; p++) begin
        v[p] = 0; s[p] = 0; e[p] = 0; d[p] = 8'($urandom);
        if (rem[p] == 0 && $urandom_range(0, 99) < 30) begin
          rem[p] = $urandom_range(1, 5);
          pos[p] = 0;
        end
        if (rem[p] > 0) begin
          if (pos[p] == 0 || $urandom_range(0, 99) < 75) begin
            if (pos[p] > 0 && $urandom_range(0, 99) < 4) begin
              rem[p] = $urandom_range(1, 5);
              pos[p] = 0;
            end
            v[p] = 1;
            s[p] = (pos[p] == 0);
            e[p] = (rem[p] == 1);
            if (pos[p] < 2) d[p] = pick_addr();
            rem[p]--;
            pos[p]++;
          end
        end else if ($urandom_range(0, 99) < 5) begin
          v[p] = 1;
          e[p] = 1'($urandom_range(0, 1));
          d[p] = pick_addr();
        end
      end
      drive(0, v, s, e, d[0], d[1], d[2]);
    end
    idle(6);
    for (int p = 0; p < 3; p++)
      chk($sformatf("drained_port%0d", p + 1), 32'(qsize(p)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
